// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the pipeline hazard controller
// Purpose: forward-select encodings, the "operand not used" Tuse value and
// the default multiply/divide busy lengths shared by RTL and its users.
package pipe_pkg;

    // D-stage operand select
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // E-stage operand select
    localparam logic [1:0] FWDE_REG = 2'd0;
    localparam logic [1:0] FWDE_M   = 2'd1;
    localparam logic [1:0] FWDE_W   = 2'd2;

    // Tuse value meaning the operand is never read
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int DEF_MULT_CYC = 5;
    localparam int DEF_DIV_CYC  = 10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// Purpose: groups the stage register numbers, Tuse/Tnew, MDU start and the
// controller's enables, bubble clear, forward selects and stall counter.
// Modports:
//   master - pipeline side: drives stage info, receives control
//   slave  - hazard controller: receives stage info, drives control
interface pipe_hazard_ctrl_if;

    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_rs;
    logic [4:0]  E_rt;
    logic [4:0]  E_a3;
    logic [4:0]  M_a3;
    logic [4:0]  W_a3;
    logic [1:0]  E_tnew;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_div;

    logic        pc_en;
    logic        fd_en;
    logic        de_clr;
    logic        md_busy;
    logic [1:0]  fwd_d_rs;
    logic [1:0]  fwd_d_rt;
    logic [1:0]  fwd_e_rs;
    logic [1:0]  fwd_e_rt;
    logic [31:0] stall_cycles;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        output E_rs, E_rt, E_a3, M_a3, W_a3, E_tnew, M_tnew,
        output E_md_start, E_md_div,
        input  pc_en, fd_en, de_clr, md_busy,
        input  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, stall_cycles
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        input  E_rs, E_rt, E_a3, M_a3, W_a3, E_tnew, M_tnew,
        input  E_md_start, E_md_div,
        output pc_en, fd_en, de_clr, md_busy,
        output fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// rtl/pipe_hazard_ctrl_md_busy_cnt.sv - multiply/divide busy counter
// Purpose: counts the E-stage busy cycles of a mult/div and flags the MDU busy.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_start     - mult/multu/div/divu in E this cycle
//   i_div       - with i_start: 1 = div class, 0 = mult class
//   o_busy      - start this cycle or cycles still outstanding
module md_busy_cnt
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load_val;

    always_comb begin
        w_load_val = i_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end

    // A start while still counting reloads; reset beats a same-cycle start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= w_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // The start cycle itself is busy so a HI/LO reader right behind it waits.
    assign o_busy = i_start | (r_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline hazard and forwarding control
// Purpose: compares D sources (with Tuse) against E/M/W destinations (with
// Tnew), stalls F/D and bubbles D/E on unresolved hazards or a busy MDU,
// chooses operand forwarding for D and E, and counts stalled cycles.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   hz         - pipe_hazard_ctrl_if.slave: stage info in, control out
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   hz
);

    logic        w_md_busy;
    logic        w_stall_rs;
    logic        w_stall_rt;
    logic        w_md_stall;
    logic        w_stall;
    logic [1:0]  w_fwd_d_rs;
    logic [1:0]  w_fwd_d_rt;
    logic [1:0]  w_fwd_e_rs;
    logic [1:0]  w_fwd_e_rt;
    logic [31:0] r_stall_cycles;

    // Operand must wait if a producer in E or M is not ready by the time D
    // needs it. Register 0 and unused operands never wait.
    function automatic logic data_stall(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        logic hit;
        hit = 1'b0;
        if (src != 5'd0 && tuse != TUSE_NONE) begin
            hit = (src == e_a3 && e_tnew > tuse) ||
                  (src == m_a3 && m_tnew > tuse);
        end
        return hit;
    endfunction

    // Nearest stage holding a ready result wins; a not-yet-ready producer is
    // skipped since the stall logic already holds D in that case.
    function automatic logic [1:0] fwd_d_sel(
        input logic [4:0] src,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (src == e_a3 && e_tnew == 2'd0) begin
                sel = FWD_E;
            end else if (src == m_a3 && m_tnew == 2'd0) begin
                sel = FWD_M;
            end else if (src == w_a3) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(
        input logic [4:0] src,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        logic [1:0] sel;
        sel = FWDE_REG;
        if (src != 5'd0) begin
            if (src == m_a3 && m_tnew == 2'd0) begin
                sel = FWDE_M;
            end else if (src == w_a3) begin
                sel = FWDE_W;
            end
        end
        return sel;
    endfunction

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_start (hz.E_md_start),
        .i_div   (hz.E_md_div),
        .o_busy  (w_md_busy)
    );

    always_comb begin
        w_stall_rs = data_stall(hz.D_rs, hz.D_tuse_rs, hz.E_a3, hz.E_tnew,
                                hz.M_a3, hz.M_tnew);
        w_stall_rt = data_stall(hz.D_rt, hz.D_tuse_rt, hz.E_a3, hz.E_tnew,
                                hz.M_a3, hz.M_tnew);
        w_md_stall = hz.D_is_md & w_md_busy;
        w_stall    = w_stall_rs | w_stall_rt | w_md_stall;
    end

    always_comb begin
        w_fwd_d_rs = fwd_d_sel(hz.D_rs, hz.E_a3, hz.E_tnew, hz.M_a3,
                               hz.M_tnew, hz.W_a3);
        w_fwd_d_rt = fwd_d_sel(hz.D_rt, hz.E_a3, hz.E_tnew, hz.M_a3,
                               hz.M_tnew, hz.W_a3);
        w_fwd_e_rs = fwd_e_sel(hz.E_rs, hz.M_a3, hz.M_tnew, hz.W_a3);
        w_fwd_e_rt = fwd_e_sel(hz.E_rt, hz.M_a3, hz.M_tnew, hz.W_a3);
    end

    // Data and MD stalls in the same cycle count once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign hz.pc_en        = ~w_stall;
    assign hz.fd_en        = ~w_stall;
    assign hz.de_clr       = w_stall;
    assign hz.md_busy      = w_md_busy;
    assign hz.fwd_d_rs     = w_fwd_d_rs;
    assign hz.fwd_d_rt     = w_fwd_d_rt;
    assign hz.fwd_e_rs     = w_fwd_e_rs;
    assign hz.fwd_e_rt     = w_fwd_e_rt;
    assign hz.stall_cycles = r_stall_cycles;

endmodule
